dshot_tx: RTL and testbench
===========================

Name: dshot_tx

Overview:
- Generates DShot frames on a single output pin from an 11-bit throttle value and a telemetry-request bit.
- Bit timing is parameterised for the 16 MHz system clock, DShot150 by default.
- Serves as the opposite end of the DShot receive path (speedhandler). Used as an on-chip stimulus source for the DShot-to-BL-Ctrl converter, and as a DShot output stage when driving DShot ESCs directly.
- Accepts one frame at a time through a valid/ready handshake.

Parameters:
- BIT_CLKS, 107, clocks per bit period (16 MHz / 150 kHz).
- T0H_CLKS, 40, high time of a '0' bit in clocks.
- T1H_CLKS, 80, high time of a '1' bit in clocks.
- GAP_CLKS, 1600, minimum low time after the last bit before the next frame may start.

Ports:
- clk  input  1  system clock, 16 MHz.
- rst  input  1  asynchronous active-high reset.
- frame_valid  input  1  request to send a frame; qualifies throttle and telemetry.
- frame_ready  output  1  high when a new frame can be accepted.
- throttle  input  11  DShot throttle/command value, 0..2047.
- telemetry  input  1  telemetry request bit.
- dshot_out  output  1  DShot line, idle low, registered.
- frame_done  output  1  one-cycle pulse when the gap after a frame completes.

Behaviour:
- Reset is asynchronous and active-high. One clock (clk); reset applies immediately and is not synchronised to clk.
- Reset values:
  - dshot_out=0, frame_ready=1, frame_done=0.
  - State IDLE; all counters 0.
- Reset mid-frame aborts the frame: dshot_out drops low asynchronously and no frame_done is produced.
- Handshake:
  - A frame is accepted on a rising clk edge where frame_valid && frame_ready.
  - throttle and telemetry are latched on that edge; later input changes have no effect on the frame in flight.
  - frame_ready deasserts in the cycle after acceptance. frame_valid while frame_ready=0 is ignored; there is no queueing.
- Frame word (16 bits, combinational from latched data at accept):
  - v = {throttle, telemetry}, 12 bits.
  - crc = (v ^ (v>>4) ^ (v>>8)) & 4'hF.
  - word = {v, crc}.
  - Transmitted MSB first (word[15] first).
- State machine:
  - IDLE → BIT on accept.
  - BIT: a cycle counter runs 0..BIT_CLKS-1.
    - dshot_out=1 while counter < (current bit ? T1H_CLKS : T0H_CLKS), else 0.
    - At counter=BIT_CLKS-1: if bit index = 15, go to GAP; otherwise advance the bit index and reset the counter.
  - GAP: dshot_out=0 for GAP_CLKS clocks. On the last gap clock, go to IDLE, pulse frame_done for one cycle, and assert frame_ready in the same cycle.
  - IDLE: dshot_out=0.
- Latency:
  - dshot_out first rises in the cycle following the accept edge, i.e. registered one clock after acceptance.
  - Frame body = 16*BIT_CLKS clocks (1712 by default).
  - Accept to frame_ready high = 16*BIT_CLKS + GAP_CLKS clocks (3312 by default).
- Back-to-back frames:
  - frame_valid held high is accepted on the edge where frame_ready is 1.
  - The next frame's first high then follows the previous gap with no extra idle cycle.
- Counter widths:
  - Bit counter sized for BIT_CLKS-1; gap counter sized for GAP_CLKS-1; bit index 4 bits.
  - No counter may wrap; each reload is explicit.
- Parameter legality: 0 < T0H_CLKS < T1H_CLKS < BIT_CLKS and GAP_CLKS ≥ 1. Simulation emits an error when violated; synthesis behaviour is undefined for illegal values.

Test Plan:
- Reset, then idle 100 clocks → dshot_out=0, frame_ready=1, frame_done=0 throughout.
- Send throttle=48, telemetry=0 → word 0x0606.
  - Check all 16 high pulses: 40 clk for '0' bits, 80 clk for '1' bits; each bit period 107 clk.
  - frame_done pulses exactly 3312 clk after accept.
- Send throttle=1000, telemetry=0 → word 0x7D0A. Send throttle=2047, telemetry=1 → word 0xFFFF, all 80-clk highs. Send throttle=0, telemetry=0 → word 0x0000, all 40-clk highs.
- Hold frame_valid high with a new value presented during frame 1 →
  - The change is ignored until frame 1 completes.
  - Frame 2 is accepted on the edge where frame_ready=1.
  - Frame 2's first high starts exactly 3312 clk after frame 1's first high.
- Assert rst during bit 7 of a frame →
  - dshot_out goes low immediately and frame_ready=1 after release.
  - No frame_done is produced.
  - The next accepted frame is transmitted complete and correct.

Source files
------------

// File: rtl/dshot_tx.sv
// -----------------------------------------------------------------------------
// dshot_tx -- DShot frame transmitter (DShot150 timing at 16 MHz by default)
//
// Takes an 11-bit throttle/command value plus a telemetry-request bit through
// a valid/ready handshake and serialises the 16-bit DShot word (12 data bits
// followed by a 4-bit XOR checksum) MSB first on a single registered pin.
// Each bit is a fixed-length period that starts high. The high time encodes
// the bit value. A fixed low gap follows the last bit.
//
// Ports:
//   clk          system clock (16 MHz)
//   rst          asynchronous active-high reset, aborts any frame in flight
//   frame_valid  request to send a frame; qualifies throttle and telemetry
//   frame_ready  high while a new frame can be accepted
//   throttle     11-bit DShot throttle/command value
//   telemetry    telemetry request bit
//   dshot_out    DShot line, idle low, registered
//   frame_done   one-cycle pulse on the final gap clock of a frame
// -----------------------------------------------------------------------------
module dshot_tx #(
   parameter int BIT_CLKS = 107,
   parameter int T0H_CLKS = 40,
   parameter int T1H_CLKS = 80,
   parameter int GAP_CLKS = 1600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_valid,
   output logic        frame_ready,
   input  logic [10:0] throttle,
   input  logic        telemetry,
   output logic        dshot_out,
   output logic        frame_done
);

   localparam int BW = $clog2(BIT_CLKS);
   localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CLKS - 1);
   localparam logic [BW-1:0] T0H      = BW'(T0H_CLKS);
   localparam logic [BW-1:0] T1H      = BW'(T1H_CLKS);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   if (!(T0H_CLKS > 0 && T0H_CLKS < T1H_CLKS && T1H_CLKS < BIT_CLKS && GAP_CLKS >= 1))
   begin : g_param_check
      $error("dshot_tx: illegal timing parameters (need 0 < T0H < T1H < BIT, GAP >= 1)");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BIT  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [3:0]    idx_q, idx_d;
   logic [15:0]   word_q, word_d;
   logic          dshot_q, dshot_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;

   logic          accept;
   logic          cur_bit;
   logic [BW-1:0] high_len;

   // 16-bit DShot word: {throttle, telemetry, crc}, crc = XOR of the three nibbles
   function automatic logic [15:0] dshot_word(input logic [10:0] thr, input logic tlm);
      logic [11:0] v;
      logic [11:0] c;
      v = {thr, tlm};
      c = v ^ (v >> 4) ^ (v >> 8);
      return {v, c[3:0]};
   endfunction

   assign accept = frame_valid && ready_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      word_d  = word_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_BIT;
               cnt_d   = '0;
               idx_d   = 4'd0;
               word_d  = dshot_word(throttle, telemetry);
            end
         end
         S_BIT: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (idx_q == 4'd15) begin
                  state_d = S_GAP;
                  gap_d   = '0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + BIT_ONE;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d = '0;
               // ready is already high on the last gap clock, so a waiting
               // frame starts straight out of the gap with no idle cycle
               if (accept) begin
                  state_d = S_BIT;
                  cnt_d   = '0;
                  idx_d   = 4'd0;
                  word_d  = dshot_word(throttle, telemetry);
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_d = gap_q + GAP_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the next state:
      // the pin then changes on the same edge the counters do.
      cur_bit  = word_d[4'd15 - idx_d];
      high_len = cur_bit ? T1H : T0H;
      dshot_d  = (state_d == S_BIT) && (cnt_d < high_len);
      done_d   = (state_d == S_GAP) && (gap_d == GAP_LAST);
      ready_d  = (state_d == S_IDLE) || done_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
         idx_q   <= 4'd0;
         dshot_q <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         dshot_q <= dshot_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   // Frame data needs no reset: it is only observed while a frame is in flight
   always_ff @(posedge clk) begin
      word_q <= word_d;
   end

   assign dshot_out   = dshot_q;
   assign frame_ready = ready_q;
   assign frame_done  = done_q;

endmodule

// File: tb/tb_dshot_tx.sv
// -----------------------------------------------------------------------------
// tb_dshot_tx -- self-checking bench for dshot_tx (default DShot150 timing)
// -----------------------------------------------------------------------------
module tb_dshot_tx;

   localparam int BIT_CLKS   = 107;
   localparam int T0H_CLKS   = 40;
   localparam int T1H_CLKS   = 80;
   localparam int GAP_CLKS   = 1600;
   localparam int BODY_CLKS  = 16 * BIT_CLKS;
   localparam int FRAME_CLKS = BODY_CLKS + GAP_CLKS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_valid = 1'b0;
   logic        frame_ready;
   logic [10:0] throttle = 11'd0;
   logic        telemetry = 1'b0;
   logic        dshot_out;
   logic        frame_done;

   int tests = 0;
   int fails = 0;

   dshot_tx #(
      .BIT_CLKS(BIT_CLKS),
      .T0H_CLKS(T0H_CLKS),
      .T1H_CLKS(T1H_CLKS),
      .GAP_CLKS(GAP_CLKS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .throttle   (throttle),
      .telemetry  (telemetry),
      .dshot_out  (dshot_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Word built arithmetically: data = 2*throttle + telemetry, crc appended.
   function automatic logic [15:0] tb_word(input int thr, input int tlm);
      int v;
      v = thr * 2 + tlm;
      return 16'(v * 16 + ((v ^ (v >> 4) ^ (v >> 8)) & 15));
   endfunction

   // ---------------- behavioural model ----------------
   // A frame is a timeline of FRAME_CLKS cycles starting the cycle after accept.
   int          cyc = 0;
   bit          m_busy = 1'b0;
   int          m_start = 0;
   logic [15:0] m_word = 16'h0;

   always @(posedge clk) begin
      bit mrdy;
      if (rst) begin
         m_busy = 1'b0;
      end else begin
         mrdy = !m_busy || (cyc - m_start == FRAME_CLKS - 1);
         if (m_busy && (cyc - m_start == FRAME_CLKS - 1)) m_busy = 1'b0;
         if (frame_valid && mrdy) begin
            m_busy  = 1'b1;
            m_word  = tb_word(int'(throttle), int'(telemetry));
            m_start = cyc + 1;
         end
      end
      cyc = cyc + 1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic ed, er, eo;
      int   rel;
      ed = 1'b0; er = 1'b1; eo = 1'b0;
      if (!rst && m_busy) begin
         rel = cyc - m_start;
         eo  = (rel == FRAME_CLKS - 1);
         er  = eo;
         if (rel < BODY_CLKS)
            ed = ((rel % BIT_CLKS) < (m_word[15 - rel / BIT_CLKS] ? T1H_CLKS : T0H_CLKS));
      end
      check_int("cmp_dshot_out",   int'(dshot_out),   int'(ed));
      check_int("cmp_frame_ready", int'(frame_ready), int'(er));
      check_int("cmp_frame_done",  int'(frame_done),  int'(eo));
   end

   // ---------------- stimulus helpers ----------------
   // Returns 2 time units after the accepting edge.
   task automatic send(input int thr, input int tlm, input bit hold);
      int   n;
      logic r;
      @(posedge clk); #2;
      frame_valid = 1'b1;
      throttle    = 11'(thr);
      telemetry   = 1'(tlm);
      n = 0;
      r = 1'b0;
      while (!r && n < 5000) begin
         @(negedge clk); r = frame_ready;
         @(posedge clk); n++;
      end
      if (!r) check_int("accept_timeout", 0, 1);
      #2;
      if (!hold) frame_valid = 1'b0;
   endtask

   // Measures each bit's high time against literal widths, then accept-to-done.
   task automatic check_pulses(input logic [15:0] w);
      int hc, n;
      n = 0;
      for (int b = 0; b < 16; b++) begin
         hc = 0;
         repeat (BIT_CLKS) begin
            @(negedge clk); n++;
            if (dshot_out) hc++;
         end
         check_int($sformatf("w%04h_bit%0d_high", w, b), hc, w[15 - b] ? 80 : 40);
      end
      do begin
         @(negedge clk); n++;
      end while (!frame_done && n < 4000);
      check_int($sformatf("w%04h_done_latency", w), n, 3312);
      check_int($sformatf("w%04h_ready_at_done", w), int'(frame_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ok, c1, c2, n, dn;

      // Model pins: words hand-computed from the checksum rule
      check_int("word_48_0",    int'(tb_word(48, 0)),   16'h0606);
      check_int("word_1000_0",  int'(tb_word(1000, 0)), 16'h7D0A);
      check_int("word_2047_1",  int'(tb_word(2047, 1)), 16'hFFFF);
      check_int("word_0_0",     int'(tb_word(0, 0)),    16'h0000);

      // Reset and idle
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      ok = 1;
      repeat (100) begin
         @(negedge clk);
         if (dshot_out !== 1'b0 || frame_ready !== 1'b1 || frame_done !== 1'b0) ok = 0;
      end
      check_int("idle_100_clean", ok, 1);

      // Single frames
      send(48, 0, 1'b0);   check_pulses(16'h0606);
      send(1000, 0, 1'b0); check_pulses(16'h7D0A);
      send(2047, 1, 1'b0); check_pulses(16'hFFFF);
      send(0, 0, 1'b0);    check_pulses(16'h0000);

      // Back-to-back with valid held and inputs changed mid-frame
      send(100, 0, 1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (!dshot_out && n < 10);
      c1 = cyc;
      check_int("b2b_first_high_latency", n, 1);
      repeat (500) @(posedge clk);
      #2 throttle = 11'd555; telemetry = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_done && n < 4000);
      check_int("b2b_frame1_done", int'(frame_done), 1);
      @(posedge clk); #2 frame_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!dshot_out && n < 10);
      c2 = cyc;
      check_int("b2b_spacing", c2 - c1, 3312);
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_done && n < 4000);
      check_int("b2b_frame2_done", int'(frame_done), 1);

      // Reset during bit 7
      send(1234, 1, 1'b0);
      repeat (7 * BIT_CLKS + 11) @(negedge clk);
      check_int("bit7_high_before_rst", int'(dshot_out), 1);
      @(posedge clk); #2 rst = 1'b1;
      #1 check_int("rst_async_low", int'(dshot_out), 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_int("ready_after_rst", int'(frame_ready), 1);
      dn = 0;
      repeat (3400) begin
         @(negedge clk);
         if (frame_done) dn++;
      end
      check_int("no_done_after_rst", dn, 0);
      send(777, 0, 1'b0); check_pulses(tb_word(777, 0));

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
